// File: rtl/mem_stage_ml_pkg.sv
// Shared types and helpers for the MEM pipeline stage: access sizes, lane
// enables, misalignment rule and the MEM/WB payload.
package mem_stage_ml_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = XLEN / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_WORDX = 2'b11
  } size_e;

  typedef struct packed {
    logic            valid;
    logic            writereg;
    logic            misaligned;
    logic [XLEN-1:0] wbvalue;
  } wb_payload_t;

  // Counter needs to reach MEM_LATENCY-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  function automatic logic [NLANES-1:0] lane_enable(input size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ml_if.sv
// EX/MEM request, stall back-pressure and MEM/WB result bundle.
interface mem_stage_ml_if #(
  parameter int unsigned REG_AW = 5
);
  logic              ex_mem_valid;
  logic              ex_mem_readmem;
  logic              ex_mem_writemem;
  logic [1:0]        ex_mem_size;
  logic              ex_mem_unsigned;
  logic [31:0]       ex_mem_regb;
  logic              ex_mem_selwsource;
  logic [REG_AW-1:0] ex_mem_regdest;
  logic              ex_mem_writereg;
  logic [31:0]       ex_mem_wbvalue;

  logic              mem_stall;
  logic              mem_wb_valid;
  logic [REG_AW-1:0] mem_wb_regdest;
  logic              mem_wb_writereg;
  logic [31:0]       mem_wb_wbvalue;
  logic              mem_wb_misaligned;

  modport master (
    output ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_size, ex_mem_unsigned,
           ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg, ex_mem_wbvalue,
    input  mem_stall, mem_wb_valid, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
           mem_wb_misaligned
  );

  modport slave (
    input  ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_size, ex_mem_unsigned,
           ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg, ex_mem_wbvalue,
    output mem_stall, mem_wb_valid, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
           mem_wb_misaligned
  );
endinterface

// File: rtl/mem_stage_ml_data_ram.sv
// Data RAM: DEPTH x 32, byte-enable synchronous write, asynchronous read,
// contents survive reset.
module mem_stage_ml_data_ram #(
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ml.sv
// MEM pipeline stage: multi-cycle access counter with stall, sub-word
// load/store steering, misalignment handling and the MEM/WB register.
module mem_stage_ml
  import mem_stage_ml_pkg::*;
#(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned REG_AW      = 5
) (
  input logic           clock,
  input logic           reset,
  mem_stage_ml_if.slave bus
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = cnt_width(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MEM_LATENCY - 1);

  size_e             size;
  logic [1:0]        off;
  logic [AW-1:0]     widx;
  logic              memop;
  logic              store;
  logic              misaligned;
  logic              stall;
  logic              ram_we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic [CW-1:0]     cnt_q, cnt_d;
  wb_payload_t       wb_q, wb_d;
  logic [REG_AW-1:0] regdest_q, regdest_d;
  logic              unused_addr_hi;

  assign size       = size_e'(bus.ex_mem_size);
  assign off        = bus.ex_mem_wbvalue[1:0];
  assign widx       = bus.ex_mem_wbvalue[AW+1:2];
  assign memop      = bus.ex_mem_valid & (bus.ex_mem_readmem | bus.ex_mem_writemem);
  assign store      = bus.ex_mem_valid & bus.ex_mem_writemem;
  assign misaligned = memop & is_misaligned(size, off);
  assign stall      = (MEM_LATENCY > 1) && memop && (cnt_q != CNT_LAST);

  // Upper address bits are ignored: the RAM index wraps modulo DEPTH.
  assign unused_addr_hi = ^bus.ex_mem_wbvalue[31:AW+2];

  // A store writes only on its retire edge, never while reset is asserted.
  assign ram_we = reset & ~stall & store & ~misaligned;
  assign be     = lane_enable(size, off);

  always_comb begin
    case (size)
      SIZE_BYTE: wdata = {4{bus.ex_mem_regb[7:0]}};
      SIZE_HALF: wdata = {2{bus.ex_mem_regb[15:0]}};
      default:   wdata = bus.ex_mem_regb;
    endcase
  end

  mem_stage_ml_data_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .be_i    (be),
    .addr_i  (widx),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  assign ld_byte = rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? rdata[31:16] : rdata[15:0];

  // Lane extraction and sign/zero extension; misaligned loads return zero.
  always_comb begin
    case (size)
      SIZE_BYTE: ld_data = {{24{~bus.ex_mem_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{~bus.ex_mem_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = rdata;
    endcase
    if (misaligned) ld_data = '0;
  end

  // Stall edges insert a bubble; retire edges load the MEM/WB register.
  always_comb begin
    cnt_d     = cnt_q;
    wb_d      = wb_q;
    regdest_d = regdest_q;
    if (stall) begin
      cnt_d         = cnt_q + CW'(1);
      wb_d.valid    = 1'b0;
      wb_d.writereg = 1'b0;
    end else begin
      cnt_d           = '0;
      wb_d.valid      = bus.ex_mem_valid;
      wb_d.writereg   = bus.ex_mem_writereg & ~misaligned;
      wb_d.misaligned = misaligned;
      wb_d.wbvalue    = bus.ex_mem_selwsource ? ld_data : bus.ex_mem_wbvalue;
      regdest_d       = bus.ex_mem_regdest;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      wb_q      <= '0;
      regdest_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      regdest_q <= regdest_d;
    end
  end

  assign bus.mem_stall         = stall;
  assign bus.mem_wb_valid      = wb_q.valid;
  assign bus.mem_wb_regdest    = regdest_q;
  assign bus.mem_wb_writereg   = wb_q.writereg;
  assign bus.mem_wb_wbvalue    = wb_q.wbvalue;
  assign bus.mem_wb_misaligned = wb_q.misaligned;

endmodule
